// File: rtl/tsmp_pkg.sv
// rtl/tsmp_pkg.sv - shared TSMP packet types, header layout and transmitter state encodings
package tsmp_pkg;

    localparam logic [7:0] TSMP_TYPE_READ      = 8'h00;
    localparam logic [7:0] TSMP_TYPE_WRITE     = 8'h01;
    localparam logic [7:0] TSMP_TYPE_READ_RESP = 8'h02;
    localparam logic [7:0] TSMP_TYPE_CONFIG    = 8'h03;
    localparam logic [7:0] TSMP_TYPE_NONE      = 8'hFF;

    localparam int HDR_LENGTH = 24;

    localparam logic [4:0] HDR_TAG_OFS  = 5'd0;
    localparam logic [4:0] HDR_TYPE_OFS = 5'd1;
    localparam logic [4:0] HDR_NUM_OFS  = 5'd18;
    localparam logic [4:0] HDR_ADDR_OFS = 5'd23;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_PAY  = 3'd4
    } tx_state_t;

endpackage

// File: rtl/hcp_tx_hdr_gen.sv
// rtl/hcp_tx_hdr_gen.sv - combinational TSMP read-response header byte selector
module hcp_tx_hdr_gen
    import tsmp_pkg::*;
(
    input  logic [4:0] index,
    input  logic [7:0] tag,
    input  logic [5:0] num,
    input  logic [5:0] addr,
    output logic [8:0] hdr_byte
);

    // Bit 8 flags start-of-frame, so only the tag byte carries it.
    always_comb begin
        hdr_byte = '0;
        if (index == HDR_TAG_OFS) begin
            hdr_byte = {1'b1, tag};
        end else if (index == HDR_TYPE_OFS) begin
            hdr_byte = {1'b0, TSMP_TYPE_READ_RESP};
        end else if (index == HDR_NUM_OFS) begin
            hdr_byte = {3'b000, num};
        end else if (index == HDR_ADDR_OFS) begin
            hdr_byte = {3'b000, addr};
        end
    end

endmodule

// File: rtl/hcp_tx.sv
// rtl/hcp_tx.sv - TSMP read-response transmitter: header then register-file words on a 9-bit byte stream
module hcp_tx
    import tsmp_pkg::*;
#(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic [7:0]            iv_tag,
    input  logic [ADDR_WIDTH-1:0] iv_addr,
    input  logic [ADDR_WIDTH-1:0] iv_num,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] ov_rd_addr,
    input  logic [31:0]           iv_rd_data,
    output logic [DATA_WIDTH-1:0] ov_data,
    output logic                  o_data_wr,
    input  logic                  i_tx_ready
);

    tx_state_t             state;
    tx_state_t             state_nxt;
    logic [4:0]            byte_cnt;
    logic [1:0]            pay_idx;
    logic [7:0]            tag_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] num_r;
    logic [31:0]           word_r;
    logic                  done_r;
    logic [8:0]            hdr_byte;
    logic [7:0]            pay_byte;
    logic                  accept;
    logic                  hdr_last;
    logic                  pay_last;
    logic                  frame_end;

    hcp_tx_hdr_gen u_hdr_gen (
        .index    (byte_cnt),
        .tag      (tag_r),
        .num      (num_r),
        .addr     (addr_r),
        .hdr_byte (hdr_byte)
    );

    assign accept    = o_data_wr & i_tx_ready;
    assign hdr_last  = (state == ST_HDR) && (byte_cnt == 5'(HDR_LENGTH - 1));
    assign pay_last  = (state == ST_PAY) && (pay_idx == 2'd3);
    // num_r already counts down in CAP, so zero here means no words remain.
    assign frame_end = accept && (hdr_last || pay_last) && (num_r == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_req) state_nxt = ST_HDR;
            ST_HDR:  if (accept && hdr_last) state_nxt = (num_r == '0) ? ST_IDLE : ST_RD;
            ST_RD:   state_nxt = ST_CAP;
            ST_CAP:  state_nxt = ST_PAY;
            ST_PAY:  if (accept && pay_last) state_nxt = (num_r == '0) ? ST_IDLE : ST_RD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            byte_cnt <= '0;
            pay_idx  <= '0;
            tag_r    <= '0;
            addr_r   <= '0;
            num_r    <= '0;
            word_r   <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= frame_end;
            case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        tag_r    <= iv_tag;
                        addr_r   <= iv_addr;
                        num_r    <= iv_num;
                        byte_cnt <= '0;
                    end
                end
                ST_HDR: begin
                    if (accept) byte_cnt <= byte_cnt + 5'd1;
                end
                ST_CAP: begin
                    word_r  <= iv_rd_data;
                    addr_r  <= addr_r + 1'b1;
                    num_r   <= num_r - 1'b1;
                    pay_idx <= '0;
                end
                ST_PAY: begin
                    if (accept) pay_idx <= pay_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (pay_idx)
            2'd0:    pay_byte = word_r[31:24];
            2'd1:    pay_byte = word_r[23:16];
            2'd2:    pay_byte = word_r[15:8];
            default: pay_byte = word_r[7:0];
        endcase
    end

    always_comb begin
        o_busy     = (state != ST_IDLE);
        o_rd_en    = (state == ST_RD);
        ov_rd_addr = addr_r;
        o_data_wr  = (state == ST_HDR) || (state == ST_PAY);
        o_done     = done_r;
        ov_data    = '0;
        if (state == ST_HDR) begin
            ov_data = DATA_WIDTH'(hdr_byte);
        end else if (state == ST_PAY) begin
            ov_data = DATA_WIDTH'({1'b0, pay_byte});
        end
    end

endmodule

// File: tb/tb_hcp_tx.sv
// tb/tb_hcp_tx.sv - scoreboard bench for the TSMP read-response transmitter
module tb_hcp_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [7:0]  tag = '0;
    logic [5:0]  addr = '0;
    logic [5:0]  num = '0;
    logic        busy, done, rd_en;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic [8:0]  data;
    logic        data_wr;
    logic        tx_ready = 1'b1;

    logic [31:0] regs [64];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          accepts = 0;
    bit          bp_en = 1'b0;

    logic [8:0]  exp_q[$];
    int          rd_addr_q[$];
    int          rd_cyc_q[$];
    int          done_cyc_q[$];

    hcp_tx dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .iv_tag     (tag),
        .iv_addr    (addr),
        .iv_num     (num),
        .o_busy     (busy),
        .o_done     (done),
        .o_rd_en    (rd_en),
        .ov_rd_addr (rd_addr),
        .iv_rd_data (rd_data),
        .ov_data    (data),
        .o_data_wr  (data_wr),
        .i_tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= regs[rd_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Expected bytes, reads and done cycle for one frame; base is the cycle i_req is high.
    task automatic push_frame(input logic [7:0] t, input logic [5:0] a, input logic [5:0] n,
                              input int base, input bit timed);
        logic [31:0] w;
        logic [5:0]  ra;
        for (int i = 0; i < 24; i++) begin
            if (i == 0)       exp_q.push_back({1'b1, t});
            else if (i == 1)  exp_q.push_back(9'h002);
            else if (i == 18) exp_q.push_back({3'b000, n});
            else if (i == 23) exp_q.push_back({3'b000, a});
            else              exp_q.push_back(9'h000);
        end
        for (int k = 0; k < int'(n); k++) begin
            ra = a + 6'(k);
            w  = regs[ra];
            rd_addr_q.push_back(int'(ra));
            rd_cyc_q.push_back(timed ? base + 25 + 6 * k : -1);
            exp_q.push_back({1'b0, w[31:24]});
            exp_q.push_back({1'b0, w[23:16]});
            exp_q.push_back({1'b0, w[15:8]});
            exp_q.push_back({1'b0, w[7:0]});
        end
        done_cyc_q.push_back(timed ? base + 25 + 6 * int'(n) : -1);
    endtask

    task automatic issue(input logic [7:0] t, input logic [5:0] a, input logic [5:0] n, input bit timed);
        @(posedge clk); #1;
        push_frame(t, a, n, cyc, timed);
        req = 1'b1; tag = t; addr = a; num = n;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || done_cyc_q.size() != 0) && c < budget) begin
            @(posedge clk);
            c++;
        end
        checks++;
        if (exp_q.size() != 0 || done_cyc_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: bytes_left=%0d done_left=%0d expected 0", exp_q.size(), done_cyc_q.size());
            exp_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete(); done_cyc_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (data_wr) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_byte", int'(data), -1);
                    end else begin
                        chk("stream_byte", int'(data), int'(exp_q[0]));
                        if (tx_ready) begin
                            void'(exp_q.pop_front());
                            accepts++;
                        end
                    end
                end else if (data !== 9'h000) begin
                    chk("idle_data_zero", int'(data), 0);
                end
                if (rd_en) begin
                    if (rd_addr_q.size() == 0) begin
                        chk("unexpected_rd_en", int'(rd_addr), -1);
                    end else begin
                        chk("rd_addr", int'(rd_addr), rd_addr_q.pop_front());
                        if (rd_cyc_q[0] >= 0) chk("rd_cycle", cyc, rd_cyc_q[0]);
                        void'(rd_cyc_q.pop_front());
                    end
                end
                if (done) begin
                    if (done_cyc_q.size() == 0) begin
                        chk("unexpected_done", cyc, -1);
                    end else begin
                        if (done_cyc_q[0] >= 0) chk("done_cycle", cyc, done_cyc_q[0]);
                        void'(done_cyc_q.pop_front());
                        chk("busy_low_at_done", int'(busy), 0);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_en) tx_ready = ~tx_ready;
        end
    end

    initial begin
        int acc0;
        int base;
        for (int i = 0; i < 64; i++) regs[i] = {8'(i), 8'(i + 1), 8'(i + 2), 8'hC0};
        regs[3]  = 32'hDEADBEEF;
        regs[4]  = 32'h01020304;
        regs[63] = 32'hA1B2C3D4;
        regs[0]  = 32'h55667788;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_data_wr", int'(data_wr), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        rst = 1'b0;

        // Header only
        issue(8'h5A, 6'd10, 6'd0, 1'b1);
        wait_drain(200);

        // Two words
        issue(8'hC3, 6'd3, 6'd2, 1'b1);
        wait_drain(200);

        // Address wrap
        issue(8'h7E, 6'd63, 6'd2, 1'b1);
        wait_drain(200);

        // Backpressure, toggling ready
        acc0 = accepts;
        @(posedge clk); #2;
        bp_en = 1'b1;
        issue(8'hA5, 6'd4, 6'd1, 1'b0);
        wait_drain(400);
        @(posedge clk); #3;
        bp_en = 1'b0;
        tx_ready = 1'b1;
        chk("bp_accept_count", accepts - acc0, 28);

        // Request while busy is ignored; busy stays high across the frame
        @(posedge clk); #1;
        base = cyc;
        push_frame(8'h33, 6'd3, 6'd1, base, 1'b1);
        req = 1'b1; tag = 8'h33; addr = 6'd3; num = 6'd1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        req = 1'b1; tag = 8'h11; addr = 6'd20; num = 6'd3;
        @(posedge clk); #1;
        req = 1'b0;
        while (cyc < base + 31) begin
            chk("busy_held", int'(busy), 1);
            @(posedge clk); #1;
        end
        wait_drain(200);

        // Reset during the second payload byte
        @(posedge clk); #1;
        base = cyc;
        push_frame(8'h44, 6'd3, 6'd2, base, 1'b1);
        req = 1'b1; tag = 8'h44; addr = 6'd3; num = 6'd2;
        @(posedge clk); #1;
        req = 1'b0;
        while (cyc < base + 28) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete(); done_cyc_q.delete();
        #1;
        chk("midrst_data_wr", int'(data_wr), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_rd_en", int'(rd_en), 0);
        chk("midrst_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        issue(8'h9C, 6'd4, 6'd1, 1'b1);
        wait_drain(200);

        chk("rd_queue_empty", rd_addr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
